// File: rtl/add_word_seq.sv
// Purpose: word-serial multi-word adder; chains carries through one shared adder_n.
// Latency: 1 cycle from input accept to out_* (single registered output stage).
// Backpressure: in_ready = !out_valid || out_ready; out_* hold while stalled.
//
// Optional feature: define ADD_WORD_SEQ_SUB_EN to add in_sub (A-B mode, B inverted,
// initial carry forced to 1, out_cout=1 means no borrow).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          operand word handshake
//   in_a, in_b                 operand words (LSW first)
//   in_first, in_last, in_cin  framing and initial carry (cin sampled on first word)
//   in_sub                     subtract mode (only with ADD_WORD_SEQ_SUB_EN)
//   out_valid/out_ready        result word handshake
//   out_sum                    result word
//   out_last, out_cout         MSW marker and final carry (0 unless out_last)
//   out_trunc                  operation cut short at MAX_WORDS (only with out_last)
//   busy                       operation in progress

module adder_n #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_in_i,
  output logic [N-1:0] s_o,
  output logic         c_out_o
);
  assign {c_out_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, c_in_i};
endmodule

module add_word_seq #(
  parameter int N         = 32,
  parameter int MAX_WORDS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         in_cin,
`ifdef ADD_WORD_SEQ_SUB_EN
  input  logic         in_sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_last,
  output logic         out_cout,
  output logic         out_trunc,
  output logic         busy
);

  localparam int            CW      = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_sum_q, out_sum_d;
  logic          out_last_q, out_last_d;
  logic          out_cout_q, out_cout_d;
  logic          out_trunc_q, out_trunc_d;
`ifdef ADD_WORD_SEQ_SUB_EN
  logic          sub_q, sub_d;
`endif

  logic          accept;
  logic          drop;
  logic          sub_eff;
  logic [N-1:0]  add_b;
  logic          add_cin;
  logic [N-1:0]  add_sum;
  logic          add_cout;
  logic [CW-1:0] cnt_next;
  logic          end_word;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // Without a first word there is no operation to attach an IDLE word to.
  assign drop     = (state_q == IDLE) && !in_first;

`ifdef ADD_WORD_SEQ_SUB_EN
  assign sub_eff = in_first ? in_sub : sub_q;
`else
  assign sub_eff = 1'b0;
`endif

  // A first word always (re)starts an operation, so it takes the fresh
  // carry-in even in RUN; this is how a framing restart drops the stale carry.
  assign add_b    = sub_eff ? ~in_b : in_b;
  assign add_cin  = in_first ? (sub_eff | in_cin) : carry_q;
  assign cnt_next = in_first ? CW'(1) : cnt_q + CW'(1);
  assign end_word = in_last || (cnt_next == MAX_CNT);

  adder_n #(.N(N)) u_adder (
    .a_i    (in_a),
    .b_i    (add_b),
    .c_in_i (add_cin),
    .s_o    (add_sum),
    .c_out_o(add_cout)
  );

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_trunc_d = out_trunc_q;
`ifdef ADD_WORD_SEQ_SUB_EN
    sub_d       = sub_q;
`endif
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      carry_d = add_cout;
      if (!drop) begin
        out_valid_d = 1'b1;
        out_sum_d   = add_sum;
        out_last_d  = end_word;
        out_cout_d  = end_word & add_cout;
        out_trunc_d = end_word & !in_last;
`ifdef ADD_WORD_SEQ_SUB_EN
        sub_d       = sub_eff;
`endif
        if (end_word) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = RUN;
          cnt_d   = cnt_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_trunc_q <= 1'b0;
`ifdef ADD_WORD_SEQ_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_trunc_q <= out_trunc_d;
`ifdef ADD_WORD_SEQ_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign out_trunc = out_trunc_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_add_word_seq.sv
// Bench for add_word_seq: vector table, directed corner sequences, and a
// randomized run scored against a transaction-level reference model.
module tb_add_word_seq;
  localparam int N  = 32;
  localparam int MW = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [N-1:0] in_a, in_b;
  logic         in_first, in_last, in_cin;
  logic         out_valid, out_ready;
  logic [N-1:0] out_sum;
  logic         out_last, out_cout, out_trunc, busy;
`ifdef ADD_WORD_SEQ_SUB_EN
  logic         in_sub;
`endif

  add_word_seq #(.N(N), .MAX_WORDS(MW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_first (in_first),
    .in_last  (in_last),
    .in_cin   (in_cin),
`ifdef ADD_WORD_SEQ_SUB_EN
    .in_sub   (in_sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_last (out_last),
    .out_cout (out_cout),
    .out_trunc(out_trunc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic [N-1:0] sum;
    logic         last;
    logic         cout;
    logic         trunc;
  } res_t;

  res_t exp_q[$];
  bit   m_inop  = 0;
  bit   m_carry = 0;
  bit   m_sub   = 0;
  int   m_cnt   = 0;

  task automatic model_accept(input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic f, input logic l, input logic c, input logic s);
    logic [63:0]  tot;
    logic [N-1:0] bb;
    logic         cc;
    res_t         r;
    if (!m_inop && !f) return;
    if (f) begin
      m_sub = s;
      m_cnt = 1;
    end else begin
      m_cnt = m_cnt + 1;
    end
    bb      = m_sub ? ~b : b;
    cc      = f ? (m_sub ? 1'b1 : c) : m_carry;
    tot     = 64'(a) + 64'(bb) + 64'(cc);
    m_carry = tot[N];
    r.sum   = tot[N-1:0];
    r.last  = l || (m_cnt == MW);
    r.cout  = r.last && tot[N];
    r.trunc = r.last && !l;
    m_inop  = !r.last;
    exp_q.push_back(r);
  endtask

  function automatic logic cur_sub();
`ifdef ADD_WORD_SEQ_SUB_EN
    return in_sub;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- cycle driver / monitor ----------------
  bit           acc      = 0;
  bit           rand_rdy = 0;
  bit           stalled  = 0;
  logic [N-1:0] s_sum;
  logic         s_last, s_cout, s_trunc;

  task automatic tick();
    res_t r;
    @(negedge clk);
    if (rst_n) begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stalled) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_word", {out_sum, out_last, out_cout, out_trunc},
            {s_sum, s_last, s_cout, s_trunc});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 1'b0);
        end else begin
          r = exp_q.pop_front();
          chk("out_word", {out_sum, out_last, out_cout, out_trunc},
              {r.sum, r.last, r.cout, r.trunc});
        end
      end
      stalled = out_valid && !out_ready;
      s_sum = out_sum; s_last = out_last; s_cout = out_cout; s_trunc = out_trunc;
      if (in_valid && in_ready) begin
        model_accept(in_a, in_b, in_first, in_last, in_cin, cur_sub());
        acc = 1;
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic f, input logic l, input logic c);
    in_valid = 1'b1; in_a = a; in_b = b; in_first = f; in_last = l; in_cin = c;
    acc = 0;
    for (int k = 0; k < 64 && !acc; k++) tick();
    if (!acc) chk("accept_timeout", in_ready, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] a, b;
    logic         f, l, c;
    logic         vld;
    logic [N-1:0] sum;
    logic         last, cout, trunc;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [N-1:0] ra, rb;
  bit           rf, rl, rc;
  int           nw;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_first = 1'b0; in_last = 1'b0; in_cin = 1'b0; out_ready = 1'b1;
`ifdef ADD_WORD_SEQ_SUB_EN
    in_sub = 1'b0;
`endif
    //                a             b             f     l     c     vld   sum           last  cout  trunc
    tbl[0] = '{32'd5,        32'd3,        1'b1, 1'b1, 1'b1, 1'b1, 32'd9,        1'b1, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[2] = '{32'd0,        32'd0,        1'b0, 1'b1, 1'b0, 1'b1, 32'h1,        1'b1, 1'b0, 1'b0};
    tbl[3] = '{32'd7,        32'd7,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{32'hFFFFFFFF, 32'd0,        1'b1, 1'b0, 1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'd10,       32'd20,       1'b1, 1'b0, 1'b0, 1'b1, 32'h1E,       1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'd1,        32'd1,        1'b0, 1'b1, 1'b0, 1'b1, 32'h2,        1'b1, 1'b0, 1'b0};
    tbl[8] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, 1'b0};

    // Reset state
    #23;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_word", {out_sum, out_last, out_cout, out_trunc}, 35'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table vectors, out_ready held high: each word's result is visible one edge later
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].l, tbl[i].c);
      chk($sformatf("tbl%0d_vld", i), out_valid, tbl[i].vld);
      if (tbl[i].vld)
        chk($sformatf("tbl%0d_word", i), {out_sum, out_last, out_cout, out_trunc},
            {tbl[i].sum, tbl[i].last, tbl[i].cout, tbl[i].trunc});
    end
    in_valid = 1'b0;
    tick();

    // Backpressure mid-operation
    send(32'h11111111, 32'h22222222, 1'b1, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'hFFFFFFFF; in_b = 32'd1; in_first = 1'b0; in_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    out_ready = 1'b1;
    send(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1'b0);
    send(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    send(32'd5, 32'd5, 1'b0, 1'b1, 1'b0);
    chk("bp_final", {out_valid, out_sum, out_last, out_cout}, {1'b1, 32'hA, 1'b1, 1'b0});
    in_valid = 1'b0;
    tick();
    chk("bp_no_dup", out_valid, 1'b0);

    // Forced end at MAX_WORDS, ninth word dropped
    for (int i = 1; i <= 9; i++) begin
      send(i, i, (i == 1), 1'b0, 1'b0);
      if (i < MW) begin
        chk($sformatf("fe%0d_last", i), {out_valid, out_last, busy}, 3'b101);
      end else if (i == MW) begin
        chk("fe8_end", {out_valid, out_sum, out_last, out_trunc, busy},
            {1'b1, 32'd16, 1'b1, 1'b1, 1'b0});
      end else begin
        chk("fe9_drop", {out_valid, busy}, 2'b00);
      end
    end
    in_valid = 1'b0;
    tick();

    // Reset in the middle of an operation with a live carry
    send(32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0);
    send(32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    exp_q.delete(); m_inop = 0; stalled = 0;
    #2;
    rst_n = 1'b1;
    send(32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
    chk("post_rst_sum", {out_valid, out_sum, out_last, out_cout}, {1'b1, 32'd2, 1'b1, 1'b0});
    in_valid = 1'b0;
    tick();

`ifdef ADD_WORD_SEQ_SUB_EN
    in_sub = 1'b1;
    send(32'd3, 32'd5, 1'b1, 1'b1, 1'b0);
    chk("sub_word", {out_sum, out_last, out_cout}, {32'hFFFFFFFE, 1'b1, 1'b0});
    in_sub = 1'b0;
    in_valid = 1'b0;
    tick();
`endif

    // Randomized operations against the reference model
    rand_rdy = 1;
    for (int op = 0; op < 250; op++) begin
      nw = $urandom_range(1, 10);
      rc = $urandom_range(0, 1);
      for (int w = 0; w < nw; w++) begin
        ra = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
        rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        rf = (w == 0);
        if ($urandom_range(0, 19) == 0) rf = !rf;
        rl = (w == nw - 1);
`ifdef ADD_WORD_SEQ_SUB_EN
        in_sub = $urandom_range(0, 1);
`endif
        if ($urandom_range(0, 4) == 0) begin
          in_valid = 1'b0;
          tick();
        end
        send(ra, rb, rf, rl, rc);
      end
    end

    // Drain
    rand_rdy = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
